// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: pointer width helper,
// status-flag reset values and the read-mode selector constants.
package sync_fifo_pkg;

  // Read-mode selector values for the FWFT parameter
  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  // Status flag values after reset and after a synchronous flush
  localparam logic FULL_RST      = 1'b0;
  localparam logic EMPTY_RST     = 1'b1;
  localparam logic AFULL_RST     = 1'b0;
  localparam logic AEMPTY_RST    = 1'b1;
  localparam logic RD_VALID_RST  = 1'b0;
  localparam logic OVERFLOW_RST  = 1'b0;
  localparam logic UNDERFLOW_RST = 1'b0;

  // Pointers and the level counter carry one extra bit so that a
  // completely full FIFO is distinguishable from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_dpram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// registered read data. No read-during-write bypass; the read register
// holds its value while the read enable is low.
module sync_dpram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through
// read mode, programmable almost-full/almost-empty thresholds, a registered
// fill level and a synchronous flush.
// Optional feature macro: SYNC_FIFO_ERR_EN builds the sticky overflow and
// underflow detectors; without it both flags are tied low.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = FWFT_STD,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH:0]   afull_th,
  input  logic [ADDR_WIDTH:0]   aempty_th,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] DEPTH_LV = PTR_W'(FIFO_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             rd_valid_q, rd_valid_d;
  logic             data_ok_q, data_ok_d;
  logic             wr_acc, rd_acc, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Accept/fetch decisions and next-state for pointers, level and flags
  always_comb begin
    wr_acc = wr_en && !full_q;
    if (FWFT == FWFT_ON) begin
      // Pop the presented word; refill the output register from the RAM
      // whenever it is empty or being popped. Registered pointers exclude
      // the word written this cycle, so a fresh address is never read.
      rd_acc = rd_en && rd_valid_q;
      ram_re = (wr_ptr_q != rd_ptr_q) && (!rd_valid_q || rd_acc);
    end else begin
      rd_acc = rd_en && !empty_q;
      ram_re = rd_acc;
    end
    if (clr) begin
      wr_acc = 1'b0;
      rd_acc = 1'b0;
      ram_re = 1'b0;
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + ONE : rd_ptr_q;

    level_d = level_q;
    if (wr_acc && !rd_acc)      level_d = level_q + ONE;
    else if (rd_acc && !wr_acc) level_d = level_q - ONE;

    if (FWFT == FWFT_ON) rd_valid_d = ram_re ? 1'b1 : (rd_acc ? 1'b0 : rd_valid_q);
    else                 rd_valid_d = rd_acc;

    // rd_data reads as zero until the first RAM read after reset/flush
    data_ok_d = data_ok_q | ram_re;

    full_d   = (level_d == DEPTH_LV);
    empty_d  = (FWFT == FWFT_ON) ? !rd_valid_d : (level_d == '0);
    afull_d  = (level_d >= afull_th);
    aempty_d = (level_d <= aempty_th);

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      full_d     = FULL_RST;
      empty_d    = EMPTY_RST;
      afull_d    = AFULL_RST;
      aempty_d   = AEMPTY_RST;
      rd_valid_d = RD_VALID_RST;
      data_ok_d  = 1'b0;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= FULL_RST;
      empty_q    <= EMPTY_RST;
      afull_q    <= AFULL_RST;
      aempty_q   <= AEMPTY_RST;
      rd_valid_q <= RD_VALID_RST;
      data_ok_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_valid_d;
      data_ok_q  <= data_ok_d;
    end
  end

  // Storage; its read register doubles as the FWFT prefetch register
  sync_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign rd_data  = data_ok_q ? ram_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign afull    = afull_q;
  assign aempty   = aempty_q;
  assign level    = level_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared only by reset or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= OVERFLOW_RST;
      underflow_q <= UNDERFLOW_RST;
    end else if (clr) begin
      overflow_q  <= OVERFLOW_RST;
      underflow_q <= UNDERFLOW_RST;
    end else begin
      if (wr_en && full_q)  overflow_q  <= 1'b1;
      if (rd_en && empty_q) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = OVERFLOW_RST;
  assign underflow = UNDERFLOW_RST;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: one standard-mode and one FWFT instance,
// table-driven vectors plus hand-written multi-cycle sequences.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] wr_data;
  logic [AW:0]   afull_th, aempty_th;

  logic          s_wr, s_rd, s_clr;
  logic [DW-1:0] s_rd_data;
  logic          s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [AW:0]   s_level;

  logic          f_wr, f_rd, f_clr;
  logic [DW-1:0] f_rd_data;
  logic          f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [AW:0]   f_level;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(s_clr), .wr_en(s_wr), .wr_data(wr_data),
    .rd_en(s_rd), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .empty(s_empty), .afull_th(afull_th), .aempty_th(aempty_th), .afull(s_afull),
    .aempty(s_aempty), .level(s_level), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .clr(f_clr), .wr_en(f_wr), .wr_data(wr_data),
    .rd_en(f_rd), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .afull_th(afull_th), .aempty_th(aempty_th), .afull(f_afull),
    .aempty(f_aempty), .level(f_level), .overflow(f_ovf), .underflow(f_unf)
  );

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [DW-1:0] data;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic          rvalid;
    logic [DW-1:0] rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [11];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_d;

  initial begin
    // Standard-mode vectors, thresholds 15/1, starting from reset
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

    rst = 1'b1; wr_data = '0; afull_th = 5'd15; aempty_th = 5'd1;
    s_wr = 0; s_rd = 0; s_clr = 0; f_wr = 0; f_rd = 0; f_clr = 0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("std_reset", {s_level, s_full, s_empty, s_afull, s_aempty, s_rd_valid, s_rd_data, s_ovf, s_unf},
          {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    check("fwft_reset", {f_level, f_full, f_empty, f_afull, f_aempty, f_rd_valid, f_rd_data, f_ovf, f_unf},
          {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});

    // Table-driven standard-mode vectors
    for (int i = 0; i < 11; i++) begin
      s_wr = tbl[i].wr; s_rd = tbl[i].rd; s_clr = tbl[i].clr; wr_data = tbl[i].data;
      step();
      check($sformatf("vec%0d", i),
            {s_level, s_full, s_empty, s_afull, s_aempty, s_rd_valid, s_rd_data},
            {tbl[i].level, tbl[i].full, tbl[i].empty, tbl[i].afull, tbl[i].aempty,
             tbl[i].rvalid, tbl[i].rdata});
    end
    s_wr = 0; s_rd = 0; s_clr = 0;

    // Fill to full, afull from level 15
    for (int i = 0; i < 16; i++) begin
      s_wr = 1'b1; wr_data = 8'(i + 1);
      step();
      check($sformatf("fill_lvl%0d", i + 1), {s_level, s_afull},
            {5'(i + 1), (i + 1 >= 15) ? 1'b1 : 1'b0});
    end
    check("full_flag", {s_full, s_empty}, {1'b1, 1'b0});
    wr_data = 8'h99;
    step();
    check("write_at_full", {s_level, s_full, s_ovf}, {5'd16, 1'b1, ERR});
    s_wr = 1'b0;

    // Drain back-to-back, data one cycle after each rd_en
    for (int i = 0; i < 16; i++) begin
      s_rd = 1'b1;
      step();
      check($sformatf("drain%0d", i), {s_rd_valid, s_rd_data}, {1'b1, 8'(i + 1)});
    end
    s_rd = 1'b0;
    step();
    check("drained", {s_rd_valid, s_empty, s_level, s_rd_data}, {1'b0, 1'b1, 5'd0, 8'h10});
    s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    check("std_underflow", {s_unf, s_level}, {ERR, 5'd0});

    // Flush at level 9 with concurrent write and read
    for (int i = 0; i < 9; i++) begin
      s_wr = 1'b1; wr_data = 8'h50 + 8'(i);
      step();
    end
    check("lvl9", s_level, 5'd9);
    s_clr = 1'b1; s_rd = 1'b1; wr_data = 8'hEE;
    step();
    s_clr = 1'b0; s_rd = 1'b0; s_wr = 1'b0;
    check("clr", {s_level, s_empty, s_full, s_aempty, s_rd_valid, s_ovf, s_unf},
          {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    check("clr_write_dropped", {s_level, s_empty, s_rd_data}, {5'd0, 1'b1, 8'h00});

    // Threshold change at level 5
    afull_th = 5'd10; aempty_th = 5'd1;
    for (int i = 0; i < 5; i++) begin
      s_wr = 1'b1; wr_data = 8'h60 + 8'(i);
      step();
    end
    s_wr = 1'b0;
    check("th_before", {s_level, s_afull, s_aempty}, {5'd5, 1'b0, 1'b0});
    afull_th = 5'd4; aempty_th = 5'd5;
    step();
    check("th_after", {s_level, s_afull, s_aempty}, {5'd5, 1'b1, 1'b1});
    s_wr = 1'b1; wr_data = 8'h65;
    step();
    s_wr = 1'b0;
    check("aempty_lvl6", {s_level, s_afull, s_aempty}, {5'd6, 1'b1, 1'b0});
    afull_th = 5'd15; aempty_th = 5'd1;

    // Asynchronous reset mid-operation discards contents immediately
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {s_level, s_empty, s_afull, s_rd_data}, {5'd0, 1'b1, 1'b0, 8'h00});
    step();
    rst = 1'b0;
    step();

    // FWFT: single word falls through two edges after the write
    f_wr = 1'b1; wr_data = 8'hA5;
    step();
    f_wr = 1'b0;
    check("fwft_edge1", {f_level, f_rd_valid, f_empty}, {5'd1, 1'b0, 1'b1});
    step();
    check("fwft_edge2", {f_rd_valid, f_rd_data, f_empty}, {1'b1, 8'hA5, 1'b0});
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fwft_pop", {f_level, f_empty, f_rd_valid}, {5'd0, 1'b1, 1'b0});
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fwft_underflow", {f_unf, f_level}, {ERR, 5'd0});

    // FWFT: sustained write+read at level 8 against a scoreboard
    for (int i = 0; i < 8; i++) begin
      f_wr = 1'b1; wr_data = 8'h30 + 8'(i);
      sb.push_back(wr_data);
      step();
    end
    f_wr = 1'b0;
    step(); step();
    check("fwft_lvl8", {f_level, f_rd_valid, f_rd_data}, {5'd8, 1'b1, 8'h30});
    for (int i = 0; i < 100; i++) begin
      wr_data = 8'($urandom_range(0, 255));
      f_wr = 1'b1; f_rd = 1'b1;
      exp_d = sb.pop_front();
      check($sformatf("stream_data%0d", i), {f_rd_valid, f_rd_data}, {1'b1, exp_d});
      sb.push_back(wr_data);
      step();
      check($sformatf("stream_lvl%0d", i), f_level, 5'd8);
    end
    f_wr = 1'b0; f_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
